mmio_port_bank: RTL
===================

MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

Interface
REQ-001 Parameter NUM_CH, default 4, meaning number of I/O channels; legal range 1..8.
REQ-002 Parameter DATA_W, default 32, meaning channel data width; legal range 8..32.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning entries per RX FIFO and per TX FIFO; must be a power of two, 2..16.
REQ-004 Parameter BASE_ADDR, default 32'h7FFF_FF00, meaning the channel window base; must be 256-byte aligned.
REQ-005 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 A  input  32  CPU byte address, the ALU result.
REQ-008 WD  input  32  CPU store data.
REQ-009 WE  input  1  CPU store strobe.
REQ-010 RE  input  1  CPU load strobe; qualifies RX pops.
REQ-011 RD  output  32  CPU load data, combinational from A.
REQ-012 Hit  output  1  high when A lies in the window BASE_ADDR .. BASE_ADDR+8*NUM_CH-1.
REQ-013 out_data  output  NUM_CH*DATA_W  TX head word per channel; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-014 out_valid  output  NUM_CH  TX FIFO non-empty, per channel.
REQ-015 out_ready  input  NUM_CH  sink accepts the TX head word, per channel.
REQ-016 in_data  input  NUM_CH*DATA_W  RX word per channel, packed the same way as out_data.
REQ-017 in_valid  input  NUM_CH  source presents an RX word, per channel.
REQ-018 in_ready  output  NUM_CH  RX FIFO not full, per channel.

Function
REQ-019 Channel c address map: DATA register at BASE_ADDR+8c, STATUS register at BASE_ADDR+8c+4; A[1:0] is ignored.
REQ-020 A store to DATA when the TX FIFO is not full SHALL push WD[DATA_W-1:0]; out_valid SHALL rise in the cycle after that edge.
REQ-021 A store to DATA when the TX FIFO is full SHALL be dropped and SHALL set the sticky TX_OVF bit.
REQ-022 A load from DATA SHALL return the RX head word, zero-extended to 32 bits; when RE is high and the FIFO is non-empty, that word SHALL be popped at the edge.
REQ-023 A load from DATA on an empty RX FIFO SHALL return 0, SHALL not pop, and SHALL set the sticky RX_UNF bit.
REQ-024 STATUS layout: bit0 RX_NE, bit1 TX_FULL, bit2 TX_OVF, bit3 RX_UNF, [12:8] RX count, [20:16] TX count; all other bits 0.
REQ-025 A store to STATUS SHALL clear TX_OVF and RX_UNF for each bit written as 1 (write-1-to-clear); all other bits are read-only.
REQ-026 An external push occurs when in_valid and in_ready are both high at the edge; an external pop occurs when out_valid and out_ready are both high at the edge.
REQ-027 in_ready SHALL equal "RX FIFO not full"; there is no same-cycle bypass when a CPU pop coincides with a full FIFO.
REQ-028 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its count unchanged and preserve data order.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; counts are $clog2(FIFO_DEPTH)+1 bits wide.
REQ-030 Outside the window, RD SHALL be 0, Hit SHALL be 0, and no state SHALL change.
REQ-031 Channels SHALL be fully independent; an access to channel c SHALL not affect any other channel.

Reset
REQ-032 Reset low SHALL asynchronously empty all FIFOs and clear all sticky bits and pointers.
REQ-033 While Reset is low: out_valid=0, in_ready=0, RD=0 (A-dependent Hit still valid).
REQ-034 A transfer in progress when Reset asserts SHALL be lost; in_ready SHALL rise in the first cycle after Reset deasserts.

Structure
REQ-035 Package mmio_pkg SHALL hold the register offsets (DATA=0, STATUS=4) and the STATUS bit-position constants.
REQ-036 Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) SHALL be instantiated 2*NUM_CH times.

Verification
REQ-037 After reset, store 0xA5 to BASE+0 -> out_valid[0]=1 next cycle, out_data[0]=0xA5; raise out_ready[0] -> out_valid[0]=0 after one edge.
REQ-038 Five stores to BASE+8 (ch1, DEPTH 4) with out_ready=0 -> STATUS1 reads TX_FULL=1, TX_OVF=1, TX count=4; store 0x4 to BASE+12 -> TX_OVF=0.
REQ-039 Drive in_data[2]=0x11, then 0x22 -> loads from BASE+16 with RE=1 return 0x11 then 0x22; a third load returns 0 and sets RX_UNF.
REQ-040 RX FIFO full with in_valid held and a CPU pop in the same cycle -> in_ready=0 during that cycle, =1 next cycle, count 4->3->4.
REQ-041 Reset pulsed low mid-burst with 3 RX words queued -> all counts 0, out_valid=0, STATUS=0 immediately, without waiting for an edge.
REQ-042 Access to BASE+8*NUM_CH -> Hit=0, RD=0, no FIFO state change.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared register map and STATUS field positions for the MMIO channel bank.
package mmio_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int unsigned ST_RX_NE   = 0;
  localparam int unsigned ST_TX_FULL = 1;
  localparam int unsigned ST_TX_OVF  = 2;
  localparam int unsigned ST_RX_UNF  = 3;
  localparam int unsigned ST_RX_CNT  = 8;
  localparam int unsigned ST_TX_CNT  = 16;
  localparam int unsigned ST_CNT_W   = 5;

  // Assemble a STATUS word; unlisted bits stay zero.
  function automatic logic [31:0] pack_status(
    input logic                rx_ne,
    input logic                tx_full,
    input logic                tx_ovf,
    input logic                rx_unf,
    input logic [ST_CNT_W-1:0] rx_cnt,
    input logic [ST_CNT_W-1:0] tx_cnt
  );
    logic [31:0] s;
    s = '0;
    s[ST_RX_NE]                 = rx_ne;
    s[ST_TX_FULL]               = tx_full;
    s[ST_TX_OVF]                = tx_ovf;
    s[ST_RX_UNF]                = rx_unf;
    s[ST_RX_CNT +: ST_CNT_W]    = rx_cnt;
    s[ST_TX_CNT +: ST_CNT_W]    = tx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word; overflowing pushes and
// underflowing pops are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mmio_port_bank.sv
// CPU-visible bank of independent TX/RX channels: per channel a DATA register
// backed by two FIFOs and a STATUS register with W1C sticky error flags.
module mmio_port_bank
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h7FFF_FF00
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [31:0]              A,
  input  logic [31:0]              WD,
  input  logic                     WE,
  input  logic                     RE,
  output logic [31:0]              RD,
  output logic                     Hit,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WIN_BYTES = 8 * NUM_CH;

  logic [31:0] offset;
  logic [2:0]  ch_idx;
  logic [2:0]  reg_ofs;
  logic        is_data;
  logic        is_status;

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] tx_push, tx_pop, tx_full, tx_empty;
  logic [NUM_CH-1:0] rx_push, rx_pop, rx_full, rx_empty;
  logic [NUM_CH-1:0] ovf_set, ovf_clr, unf_set, unf_clr;
  logic [NUM_CH-1:0] tx_ovf, rx_unf;
  logic [CW-1:0]     tx_cnt [NUM_CH];
  logic [CW-1:0]     rx_cnt [NUM_CH];
  logic [DATA_W-1:0] tx_head [NUM_CH];
  logic [DATA_W-1:0] rx_head [NUM_CH];
  logic [31:0]       status [NUM_CH];
  logic [31:0]       rdword [NUM_CH];
  logic [31:0]       rd_c;

  // Unsigned offset makes addresses below the base wrap high and miss.
  assign offset    = A - BASE_ADDR;
  assign Hit       = (offset < WIN_BYTES);
  assign ch_idx    = offset[5:3];
  assign reg_ofs   = {offset[2], 2'b00};
  assign is_data   = (reg_ofs == REG_DATA);
  assign is_status = (reg_ofs == REG_STATUS);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_d, rd_d, wr_s;

    assign sel[c] = Hit && (ch_idx == 3'(c));
    assign wr_d   = WE && sel[c] && is_data;
    assign rd_d   = RE && sel[c] && is_data;
    assign wr_s   = WE && sel[c] && is_status;

    assign tx_push[c] = wr_d && !tx_full[c];
    assign ovf_set[c] = wr_d && tx_full[c];
    assign rx_pop[c]  = rd_d && !rx_empty[c];
    assign unf_set[c] = rd_d && rx_empty[c];
    assign ovf_clr[c] = wr_s && WD[ST_TX_OVF];
    assign unf_clr[c] = wr_s && WD[ST_RX_UNF];

    // Handshakes are forced idle while reset is held.
    assign in_ready[c]  = Reset && !rx_full[c];
    assign out_valid[c] = Reset && !tx_empty[c];
    assign rx_push[c]   = in_valid[c] && in_ready[c];
    assign tx_pop[c]    = out_valid[c] && out_ready[c];

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (CLK),
      .rst_n (Reset),
      .push  (tx_push[c]),
      .pop   (tx_pop[c]),
      .wdata (WD[DATA_W-1:0]),
      .rdata (tx_head[c]),
      .full  (tx_full[c]),
      .empty (tx_empty[c]),
      .count (tx_cnt[c])
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (CLK),
      .rst_n (Reset),
      .push  (rx_push[c]),
      .pop   (rx_pop[c]),
      .wdata (in_data[c*DATA_W +: DATA_W]),
      .rdata (rx_head[c]),
      .full  (rx_full[c]),
      .empty (rx_empty[c]),
      .count (rx_cnt[c])
    );

    assign out_data[c*DATA_W +: DATA_W] = tx_head[c];
    assign rdword[c] = rx_empty[c] ? 32'd0 : 32'(rx_head[c]);
    assign status[c] = pack_status(!rx_empty[c], tx_full[c], tx_ovf[c], rx_unf[c],
                                   ST_CNT_W'(rx_cnt[c]), ST_CNT_W'(tx_cnt[c]));
  end

  // Sticky error flags: set on a faulting DATA access, cleared by W1C.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      tx_ovf <= '0;
      rx_unf <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ovf_set[c])      tx_ovf[c] <= 1'b1;
        else if (ovf_clr[c]) tx_ovf[c] <= 1'b0;
        if (unf_set[c])      rx_unf[c] <= 1'b1;
        else if (unf_clr[c]) rx_unf[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sel[c]) rd_c = is_status ? status[c] : rdword[c];
    end
  end

  assign RD = Reset ? rd_c : 32'd0;

endmodule
